guess_checker: RTL and testbench
================================

GUESS_CHECKER -- requirements
Module: guess_checker

Interface
REQ-001 Parameter WORD_LEN, default 5, letters per guess (1..7).
REQ-002 Parameter MAX_GUESS, default 6, guesses allowed per game (1..7).
REQ-003 clk  in  1  clock; all state updates on rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 let_valid  in  1  one-cycle strobe; commit let_ascii to the guess buffer.
REQ-006 let_ascii  in  7  committed letter, uppercase ASCII 'A'(0x41)..'Z'(0x5A).
REQ-007 del  in  1  one-cycle strobe; remove last buffered letter.
REQ-008 submit  in  1  one-cycle strobe; evaluate the full buffer.
REQ-009 secret  in  7*WORD_LEN  target word, letter i at [7i+6:7i].
REQ-010 word  out  7*WORD_LEN  guess buffer, letter i at [7i+6:7i], letter 0 entered first; unfilled slots 0.
REQ-011 count  out  3  letters currently buffered.
REQ-012 let_ready  out  1  high in ENTRY while count<WORD_LEN.
REQ-013 result  out  2*WORD_LEN  per-letter code at [2i+1:2i]: 00 none, 01 absent, 10 present, 11 exact.
REQ-014 res_valid  out  1  one-cycle pulse when result updates.
REQ-015 guess_num  out  3  completed guesses this game.
REQ-016 win, lose  out  1 each  sticky game-end flags.

Function
REQ-017 FSM states ENTRY, EXACT, PRES, REPORT, OVER; ENTRY after reset.
REQ-018 ENTRY input priority per cycle: del > submit > let_valid; lower-priority strobes in the same cycle are dropped.
REQ-019 let_valid accepted only if count<WORD_LEN and 0x41<=let_ascii<=0x5A: letter written to slot count, count+1; otherwise ignored.
REQ-020 del with count>0: slot count-1 cleared to 0, count-1; with count==0 ignored.
REQ-021 submit with count==WORD_LEN: secret latched internally, go to EXACT; with count<WORD_LEN ignored.
REQ-022 EXACT (1 cycle): slots with word[i]==secret[i] marked 11 and their secret letters marked consumed; all other slots marked 01 provisionally.
REQ-023 PRES (WORD_LEN cycles, index i=0..WORD_LEN-1, one per cycle): if slot i not exact, lowest unconsumed secret position j with matching letter is consumed and slot i set to 10; none found leaves 01.
REQ-024 REPORT (1 cycle): result output updated, res_valid=1, guess_num+1.
REQ-025 res_valid is high in exactly the cycle WORD_LEN+2 rising edges after the edge sampling the accepted submit.
REQ-026 REPORT exit: all slots 11 -> win=1, OVER; else guess_num==MAX_GUESS -> lose=1, OVER; else ENTRY with word=0, count=0.
REQ-027 result holds its value until the next REPORT; EXACT/PRES work on an internal copy.
REQ-028 In EXACT, PRES, REPORT and OVER, let_valid, del and submit are ignored; let_ready=0.
REQ-029 secret changes after the submit edge have no effect on the guess in progress.
REQ-030 OVER is terminal until rst; win/lose never both 1.

Reset
REQ-031 rst forces at once, from any state: state=ENTRY, word=0, count=0, result=0, res_valid=0, guess_num=0, win=0, lose=0, let_ready=1, internal copies cleared.
REQ-032 rst mid-EXACT/PRES discards the guess in progress; no res_valid pulse.

Verification (secret="CRANE", defaults)
REQ-033 Assert rst -> all outputs 0 except let_ready=1; count=0.
REQ-034 Letters C,R,A,N,E then submit -> res_valid exactly 7 cycles after the submit edge, result all 11 (0x3FF), guess_num=1, win=1, then state OVER.
REQ-035 Guess "ERROR" -> result slots 0..4 = 10,11,01,01,01 (shows duplicate-R consumption); guess_num=1; count=0, back in ENTRY.
REQ-036 del at count=0, let_valid with 0x40 and 0x5B, submit at count=3, del+let_valid same cycle -> no change except a del of the last letter; count checked each step.
REQ-037 Six wrong guesses -> lose=1 after the 6th res_valid; further letters and submits ignored; win stays 0.
REQ-038 rst during PRES -> all outputs return to reset values within the same cycle; no res_valid pulse follows.

Source files
------------

// File: rtl/guess_checker.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | guess_checker: word-guess entry buffer and exact/present letter scoring  |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module guess_checker #(
  parameter int WORD_LEN  = 5,
  parameter int MAX_GUESS = 6
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    let_valid,
  input  logic [6:0]              let_ascii,
  input  logic                    del,
  input  logic                    submit,
  input  logic [7*WORD_LEN-1:0]   secret,
  output logic [7*WORD_LEN-1:0]   word,
  output logic [2:0]              count,
  output logic                    let_ready,
  output logic [2*WORD_LEN-1:0]   result,
  output logic                    res_valid,
  output logic [2:0]              guess_num,
  output logic                    win,
  output logic                    lose
);

  typedef enum logic [2:0] {
    ENTRY  = 3'd0,
    EXACT  = 3'd1,
    PRES   = 3'd2,
    REPORT = 3'd3,
    OVER   = 3'd4
  } state_t;

  localparam logic [2:0] WL = 3'(WORD_LEN);
  localparam logic [2:0] MG = 3'(MAX_GUESS);

  state_t                  state, state_nx;
  logic [7*WORD_LEN-1:0]   sec;
  logic [2*WORD_LEN-1:0]   work;
  logic [WORD_LEN-1:0]     consumed;
  logic [WORD_LEN-1:0]     hit;
  logic [2:0]              idx;
  logic                    do_del, do_sub, do_let;
  logic                    all_exact, last_guess;
  logic [6:0]              cur_let;
  logic                    cur_exact, found;

  // del outranks submit, which outranks let_valid; outranked strobes are dropped
  assign do_del = (state == ENTRY) && del && (count != 3'd0);
  assign do_sub = (state == ENTRY) && !del && submit && (count == WL);
  assign do_let = (state == ENTRY) && !del && !submit && let_valid && (count < WL) &&
                  (let_ascii >= 7'h41) && (let_ascii <= 7'h5A);

  assign let_ready  = (state == ENTRY) && (count < WL);
  assign last_guess = ((guess_num + 3'd1) == MG);

  always_comb begin
    all_exact = 1'b1;
    for (int i = 0; i < WORD_LEN; i++) begin
      if (work[2*i +: 2] != 2'b11) all_exact = 1'b0;
    end
  end

  // Lowest unconsumed secret position matching the letter at the current scan index
  always_comb begin
    cur_let   = '0;
    cur_exact = 1'b0;
    hit       = '0;
    for (int i = 0; i < WORD_LEN; i++) begin
      if (idx == 3'(i)) begin
        cur_let   = word[7*i +: 7];
        cur_exact = (work[2*i +: 2] == 2'b11);
      end
    end
    found = cur_exact;
    for (int j = 0; j < WORD_LEN; j++) begin
      if (!found && !consumed[j] && (sec[7*j +: 7] == cur_let)) begin
        hit[j] = 1'b1;
        found  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ENTRY;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ENTRY:   if (do_sub) state_nx = EXACT;
      EXACT:   state_nx = PRES;
      PRES:    if (idx == WL - 3'd1) state_nx = REPORT;
      REPORT:  state_nx = (all_exact || last_guess) ? OVER : ENTRY;
      OVER:    state_nx = OVER;
      default: state_nx = ENTRY;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word      <= '0;
      count     <= '0;
      result    <= '0;
      res_valid <= 1'b0;
      guess_num <= '0;
      win       <= 1'b0;
      lose      <= 1'b0;
      sec       <= '0;
      work      <= '0;
      consumed  <= '0;
      idx       <= '0;
    end else begin
      res_valid <= 1'b0;
      case (state)
        ENTRY: begin
          if (do_del) begin
            for (int i = 0; i < WORD_LEN; i++) begin
              if (3'(i) == count - 3'd1) word[7*i +: 7] <= '0;
            end
            count <= count - 3'd1;
          end else if (do_sub) begin
            sec <= secret;
          end else if (do_let) begin
            for (int i = 0; i < WORD_LEN; i++) begin
              if (3'(i) == count) word[7*i +: 7] <= let_ascii;
            end
            count <= count + 3'd1;
          end
        end
        EXACT: begin
          for (int i = 0; i < WORD_LEN; i++) begin
            if (word[7*i +: 7] == sec[7*i +: 7]) begin
              work[2*i +: 2] <= 2'b11;
              consumed[i]    <= 1'b1;
            end else begin
              work[2*i +: 2] <= 2'b01;
              consumed[i]    <= 1'b0;
            end
          end
          idx <= '0;
        end
        PRES: begin
          if (|hit) begin
            for (int i = 0; i < WORD_LEN; i++) begin
              if (idx == 3'(i)) work[2*i +: 2] <= 2'b10;
            end
          end
          consumed <= consumed | hit;
          idx      <= idx + 3'd1;
        end
        REPORT: begin
          result    <= work;
          res_valid <= 1'b1;
          guess_num <= guess_num + 3'd1;
          if (all_exact) begin
            win <= 1'b1;
          end else if (last_guess) begin
            lose <= 1'b1;
          end else begin
            word  <= '0;
            count <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_guess_checker.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_guess_checker: directed and randomized games against a scoring model  |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_guess_checker;
  localparam int W  = 5;
  localparam int MG = 6;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             let_valid = 1'b0;
  logic [6:0]       let_ascii = '0;
  logic             del = 1'b0;
  logic             submit = 1'b0;
  logic [7*W-1:0]   secret = '0;
  logic [7*W-1:0]   word;
  logic [2:0]       count;
  logic             let_ready;
  logic [2*W-1:0]   result;
  logic             res_valid;
  logic [2:0]       guess_num;
  logic             win, lose;

  guess_checker #(.WORD_LEN(W), .MAX_GUESS(MG)) dut (
    .clk(clk), .rst(rst), .let_valid(let_valid), .let_ascii(let_ascii),
    .del(del), .submit(submit), .secret(secret), .word(word), .count(count),
    .let_ready(let_ready), .result(result), .res_valid(res_valid),
    .guess_num(guess_num), .win(win), .lose(lose)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Game model: typed letters, score of last guess, guesses taken, end flags
  logic [6:0]     m_let[$];
  logic [2*W-1:0] m_res;
  int             m_gn;
  bit             m_win, m_lose;
  logic [7*W-1:0] gsec;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7*W-1:0] s2w(input string s);
    logic [7*W-1:0] r;
    byte b;
    r = '0;
    for (int i = 0; i < W; i++) begin
      b = s[i];
      r[7*i +: 7] = b[6:0];
    end
    return r;
  endfunction

  function automatic logic [7*W-1:0] m_word();
    logic [7*W-1:0] r;
    r = '0;
    foreach (m_let[i]) r[7*i +: 7] = m_let[i];
    return r;
  endfunction

  // Letter-count scoring: exact matches first, then present letters drawn
  // from the remaining (non-exact) secret letter pool, left to right.
  function automatic logic [2*W-1:0] score(input logic [7*W-1:0] g, input logic [7*W-1:0] s);
    int             remain[128];
    logic [2*W-1:0] r;
    logic [6:0]     gc, sc;
    r = '0;
    foreach (remain[k]) remain[k] = 0;
    for (int i = 0; i < W; i++) begin
      gc = g[7*i +: 7];
      sc = s[7*i +: 7];
      if (gc == sc) r[2*i +: 2] = 2'b11;
      else remain[sc]++;
    end
    for (int i = 0; i < W; i++) begin
      gc = g[7*i +: 7];
      if (r[2*i +: 2] != 2'b11) begin
        if (remain[gc] > 0) begin
          r[2*i +: 2] = 2'b10;
          remain[gc]--;
        end else begin
          r[2*i +: 2] = 2'b01;
        end
      end
    end
    return r;
  endfunction

  function automatic bit m_over();
    return m_win || m_lose;
  endfunction

  task automatic check_state(input string tag);
    chk({tag, "_count"}, 64'(count), 64'(m_let.size()));
    chk({tag, "_word"}, 64'(word), 64'(m_word()));
    chk({tag, "_ready"}, 64'(let_ready), 64'(!m_over() && m_let.size() < W));
    chk({tag, "_gnum"}, 64'(guess_num), 64'(m_gn));
    chk({tag, "_winlose"}, {62'd0, win, lose}, {62'd0, m_win, m_lose});
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    #2;
    chk({tag, "_word"}, 64'(word), 64'd0);
    chk({tag, "_count"}, 64'(count), 64'd0);
    chk({tag, "_result"}, 64'(result), 64'd0);
    chk({tag, "_flags"}, {60'd0, res_valid, win, lose, let_ready}, 64'b0001);
    chk({tag, "_gnum"}, 64'(guess_num), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    m_let.delete();
    m_gn = 0; m_win = 0; m_lose = 0; m_res = '0;
  endtask

  task automatic press(input logic [6:0] c);
    let_valid = 1'b1;
    let_ascii = c;
    tick();
    let_valid = 1'b0;
    if (!m_over() && m_let.size() < W && c >= 7'h41 && c <= 7'h5A) m_let.push_back(c);
  endtask

  task automatic press_del();
    del = 1'b1;
    tick();
    del = 1'b0;
    if (!m_over() && m_let.size() > 0) void'(m_let.pop_back());
  endtask

  task automatic do_submit(input string tag);
    logic [7*W-1:0] held;
    int n;
    bit seen;
    held = secret;
    submit = 1'b1;
    tick();
    submit = 1'b0;
    if (m_over() || m_let.size() < W) begin
      seen = 0;
      for (int k = 0; k < W + 4; k++) begin
        if (res_valid) seen = 1;
        tick();
      end
      chk({tag, "_ignored_nopulse"}, 64'(seen), 64'd0);
      check_state({tag, "_ignored"});
      return;
    end
    n = 0;
    for (int k = 1; k <= W + 6; k++) begin
      secret = {$urandom, $urandom};
      tick();
      n = k;
      if (res_valid) break;
    end
    secret = gsec;
    chk({tag, "_latency"}, 64'(n), 64'(W + 2));
    m_res = score(m_word(), held);
    m_gn++;
    if (m_res == {2*W{1'b1}}) m_win = 1;
    else if (m_gn == MG) m_lose = 1;
    else m_let.delete();
    chk({tag, "_result"}, 64'(result), 64'(m_res));
    check_state(tag);
    tick();
    chk({tag, "_pulse_end"}, 64'(res_valid), 64'd0);
    chk({tag, "_result_hold"}, 64'(result), 64'(m_res));
  endtask

  task automatic play(input logic [7*W-1:0] g, input string tag);
    for (int i = 0; i < W; i++) press(g[7*i +: 7]);
    do_submit(tag);
  endtask

  // Random guess from the first 'span' letters, with occasional stray codes
  task automatic play_random(input int span, input string tag);
    logic [6:0] c;
    while (!m_over() && m_let.size() < W) begin
      if ($urandom_range(0, 3) == 0) press(7'($urandom_range(0, 127)));
      else if ($urandom_range(0, 7) == 0) press_del();
      else begin
        c = 7'(7'h41 + $urandom_range(0, span - 1));
        press(c);
      end
    end
    do_submit(tag);
  endtask

  initial begin
    bit seen;

    // Reset values and a winning first guess
    do_reset("rst0");
    gsec = s2w("CRANE");
    secret = gsec;
    play(s2w("CRANE"), "crane");
    chk("crane_result_const", 64'(result), 64'h3FF);
    chk("crane_win", 64'(win), 64'd1);
    press(7'h41);
    do_submit("over_win");

    // Duplicate-letter consumption
    do_reset("rst1");
    play(s2w("ERROR"), "error");
    chk("error_result_const", 64'(result), 64'h15E);

    // Entry boundary cases
    press_del();
    check_state("del_empty");
    press(7'h40);
    check_state("below_A");
    press(7'h5B);
    check_state("above_Z");
    press(7'h41); press(7'h42); press(7'h43);
    check_state("three");
    do_submit("short");
    del = 1'b1; let_valid = 1'b1; let_ascii = 7'h5A;
    tick();
    del = 1'b0; let_valid = 1'b0;
    void'(m_let.pop_back());
    check_state("del_and_let");

    // Guaranteed loss: guesses drawn from A..E can never spell CRANE
    do_reset("rst2");
    while (!m_over()) play_random(5, "lose_game");
    chk("lose_flag", 64'(lose), 64'd1);
    press(7'h43);
    press_del();
    do_submit("over_lose");
    chk("lose_win_clear", 64'(win), 64'd0);

    // Random secret over a small alphabet so duplicates and wins occur
    for (int g = 0; g < 3; g++) begin
      do_reset("rst_rand");
      for (int i = 0; i < W; i++) gsec[7*i +: 7] = 7'(7'h41 + $urandom_range(0, 2));
      secret = gsec;
      while (!m_over()) play_random(3, "rand_game");
    end

    // Reset in the middle of scoring
    do_reset("rst3");
    gsec = s2w("CRANE");
    secret = gsec;
    for (int i = 0; i < W; i++) press(7'h41 + 7'(i));
    submit = 1'b1;
    tick();
    submit = 1'b0;
    tick();
    tick();
    do_reset("rst_pres");
    seen = 0;
    for (int k = 0; k < W + 6; k++) begin
      if (res_valid) seen = 1;
      tick();
    end
    chk("rst_pres_nopulse", 64'(seen), 64'd0);
    check_state("after_rst_pres");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
`default_nettype wire
